// File: rtl/eth_tx_word_unpack_pkg.sv
// Shared types and constants for the TX word-to-byte unpacker.
// Byte lane selection lives here so the datapath and any checker agree on ordering.
package eth_tx_word_unpack_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int IDX_W          = 2;
    localparam int BYTE_W         = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // MSB-first streams walk the word from the top lane downward.
    function automatic logic [IDX_W-1:0] lane_for_idx(input logic [IDX_W-1:0] idx,
                                                      input logic             lsb_first);
        return lsb_first ? idx : (IDX_W'(BYTES_PER_WORD - 1) - idx);
    endfunction

endpackage

// File: rtl/eth_tx_word_unpack_if.sv
// FIFO read port, byte stream and frame control bundled for the TX unpacker.
// master is the unpacker side, slave is the FIFO/MAC/controller side.
interface eth_tx_word_unpack_if #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 11
);
    logic              start;
    logic [LEN_W-1:0]  frame_len;
    logic              busy;
    logic              done;
    logic              fifo_rd_en;
    logic [DATA_W-1:0] fifo_rd_data;
    logic              fifo_rd_empty;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_last;
    logic              tx_ready;

    modport master (
        input  start, frame_len, fifo_rd_data, fifo_rd_empty, tx_ready,
        output busy, done, fifo_rd_en, tx_data, tx_valid, tx_last
    );

    modport slave (
        output start, frame_len, fifo_rd_data, fifo_rd_empty, tx_ready,
        input  busy, done, fifo_rd_en, tx_data, tx_valid, tx_last
    );

endinterface

// File: rtl/eth_tx_word_unpack_word.sv
// Two-deep word buffer (current + prefetch) with the byte select mux.
// An arriving word fills whichever slot is free after this cycle's advance.
module eth_tx_word_unpack_word
    import eth_tx_word_unpack_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int LSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              advance,
    input  logic [IDX_W-1:0]  idx,
    output logic              cur_valid,
    output logic              nxt_valid,
    output logic [BYTE_W-1:0] byte_out
);

    logic [DATA_W-1:0] cur_word;
    logic [DATA_W-1:0] nxt_word;
    logic [IDX_W-1:0]  lane;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_word  <= '0;
            nxt_word  <= '0;
            cur_valid <= 1'b0;
            nxt_valid <= 1'b0;
        end else if (advance) begin
            if (nxt_valid) begin
                cur_word  <= nxt_word;
                nxt_valid <= load;
                if (load) begin
                    nxt_word <= load_data;
                end
            end else begin
                cur_valid <= load;
                if (load) begin
                    cur_word <= load_data;
                end
            end
        end else if (load) begin
            if (!cur_valid) begin
                cur_word  <= load_data;
                cur_valid <= 1'b1;
            end else begin
                nxt_word  <= load_data;
                nxt_valid <= 1'b1;
            end
        end
    end

    assign lane     = lane_for_idx(idx, LSB_FIRST != 0);
    assign byte_out = cur_word[int'(lane) * BYTE_W +: BYTE_W];

endmodule

// File: rtl/eth_tx_word_unpack.sv
// TX reader: pulls 32-bit words from the frame FIFO and streams them as bytes.
// Reads are throttled so in-flight plus buffered words never exceed the two-word buffer.
module eth_tx_word_unpack
    import eth_tx_word_unpack_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int LEN_W      = 11,
    parameter int RD_LATENCY = 1,
    parameter int LSB_FIRST  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    eth_tx_word_unpack_if.master bus
);

    state_t           state;
    state_t           state_nxt;
    logic [LEN_W-2:0] words_to_fetch;
    logic [LEN_W-2:0] words_for_len;
    logic [LEN_W-1:0] bytes_left;
    logic [IDX_W-1:0] idx;
    logic [RD_LATENCY-1:0] rd_pipe;
    logic             done_q;
    logic             cur_valid;
    logic             nxt_valid;
    logic [BYTE_W-1:0] byte_out;
    logic [1:0]       in_flight;
    logic [2:0]       occupancy;
    logic             launch;
    logic             rd_en;
    logic             handshake;
    logic             last_byte;
    logic             advance_word;
    logic             arrive;
    logic             final_pending;

    assign words_for_len = (LEN_W-1)'(bus.frame_len[LEN_W-1:2])
                         + (LEN_W-1)'(bus.frame_len[1:0] != 2'b00);
    assign arrive        = rd_pipe[RD_LATENCY-1];
    assign final_pending = (bytes_left == LEN_W'(1));

    always_comb begin
        in_flight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            in_flight = in_flight + 2'(rd_pipe[i]);
        end
        occupancy = 3'(in_flight) + 3'(cur_valid) + 3'(nxt_valid);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        rd_en     = 1'b0;
        handshake = 1'b0;
        last_byte = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start && bus.frame_len != '0) begin
                    launch    = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                rd_en     = !bus.fifo_rd_empty && words_to_fetch != '0 && occupancy < 3'd2;
                handshake = cur_valid && bus.tx_ready;
                last_byte = handshake && final_pending;
                if (last_byte) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // A word is retired at its fourth byte or at the frame's final byte, whichever comes first.
    assign advance_word = handshake && (idx == IDX_W'(BYTES_PER_WORD - 1) || last_byte);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            words_to_fetch <= '0;
            bytes_left     <= '0;
            idx            <= '0;
            rd_pipe        <= '0;
            done_q         <= 1'b0;
        end else begin
            rd_pipe <= RD_LATENCY'({rd_pipe, rd_en});
            done_q  <= last_byte;
            if (launch) begin
                words_to_fetch <= words_for_len;
                bytes_left     <= bus.frame_len;
                idx            <= '0;
            end else begin
                if (rd_en) begin
                    words_to_fetch <= words_to_fetch - (LEN_W-1)'(1);
                end
                if (handshake) begin
                    bytes_left <= bytes_left - LEN_W'(1);
                    idx        <= last_byte ? '0 : idx + IDX_W'(1);
                end
            end
        end
    end

    eth_tx_word_unpack_word #(
        .DATA_W    (DATA_W),
        .LSB_FIRST (LSB_FIRST)
    ) u_word (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (arrive),
        .load_data (bus.fifo_rd_data),
        .advance   (advance_word),
        .idx       (idx),
        .cur_valid (cur_valid),
        .nxt_valid (nxt_valid),
        .byte_out  (byte_out)
    );

    assign bus.fifo_rd_en = rd_en;
    assign bus.tx_data    = byte_out;
    assign bus.tx_valid   = cur_valid;
    assign bus.tx_last    = cur_valid && final_pending;
    assign bus.busy       = (state == ST_RUN);
    assign bus.done       = done_q;

endmodule

// File: tb/tb_eth_tx_word_unpack.sv
// Directed bench for eth_tx_word_unpack: LSB-first/latency-1 instance plus an MSB-first/latency-2 instance.
// Each instance has its own FIFO model and byte monitor; checks are immediate assertions.
module tb_eth_tx_word_unpack;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   start_cyc = 0;

    eth_tx_word_unpack_if #(.DATA_W(32), .LEN_W(11)) bus_a ();
    eth_tx_word_unpack_if #(.DATA_W(32), .LEN_W(11)) bus_b ();

    eth_tx_word_unpack #(.DATA_W(32), .LEN_W(11), .RD_LATENCY(1), .LSB_FIRST(1)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    eth_tx_word_unpack #(.DATA_W(32), .LEN_W(11), .RD_LATENCY(2), .LSB_FIRST(0)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] mem_a [16];
    logic [31:0] mem_b [16];
    int wr_a = 0, rd_a = 0, rd_cnt_a = 0, over_a = 0;
    int wr_b = 0, rd_b = 0, rd_cnt_b = 0, over_b = 0;
    logic [31:0] stage_b;

    assign bus_a.fifo_rd_empty = (rd_a == wr_a);
    assign bus_b.fifo_rd_empty = (rd_b == wr_b);

    // FIFO models share the DUT reset, as the real FIFO does.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_a <= 0; rd_cnt_a <= 0; over_a <= 0;
            bus_a.fifo_rd_data <= '0;
        end else if (bus_a.fifo_rd_en) begin
            rd_cnt_a <= rd_cnt_a + 1;
            if (rd_a == wr_a) over_a <= over_a + 1;
            else begin
                bus_a.fifo_rd_data <= mem_a[rd_a];
                rd_a <= rd_a + 1;
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_b <= 0; rd_cnt_b <= 0; over_b <= 0;
            stage_b <= '0;
            bus_b.fifo_rd_data <= '0;
        end else begin
            bus_b.fifo_rd_data <= stage_b;
            if (bus_b.fifo_rd_en) begin
                rd_cnt_b <= rd_cnt_b + 1;
                if (rd_b == wr_b) over_b <= over_b + 1;
                else begin
                    stage_b <= mem_b[rd_b];
                    rd_b <= rd_b + 1;
                end
            end
        end
    end

    logic [7:0] byte_q_a[$], byte_q_b[$];
    bit         last_q_a[$], last_q_b[$];
    int         cyc_q_a[$], cyc_q_b[$];
    int         done_cnt_a = 0, done_cyc_a = 0, done_cnt_b = 0;
    logic       done_busy_a = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            byte_q_a.delete(); last_q_a.delete(); cyc_q_a.delete();
            done_cnt_a = 0;
        end else begin
            if (bus_a.tx_valid && bus_a.tx_ready) begin
                byte_q_a.push_back(bus_a.tx_data);
                last_q_a.push_back(bus_a.tx_last);
                cyc_q_a.push_back(cyc);
            end
            if (bus_a.done) begin
                done_cnt_a++;
                done_cyc_a  = cyc;
                done_busy_a = bus_a.busy;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            byte_q_b.delete(); last_q_b.delete(); cyc_q_b.delete();
            done_cnt_b = 0;
        end else begin
            if (bus_b.tx_valid && bus_b.tx_ready) begin
                byte_q_b.push_back(bus_b.tx_data);
                last_q_b.push_back(bus_b.tx_last);
                cyc_q_b.push_back(cyc);
            end
            if (bus_b.done) done_cnt_b++;
        end
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus_a.start = 1'b0; bus_a.frame_len = '0; bus_a.tx_ready = 1'b1;
        bus_b.start = 1'b0; bus_b.frame_len = '0; bus_b.tx_ready = 1'b1;
        wr_a = 0; wr_b = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic push_a(input logic [31:0] w);
        mem_a[wr_a] = w;
        wr_a++;
    endtask

    task automatic push_b(input logic [31:0] w);
        mem_b[wr_b] = w;
        wr_b++;
    endtask

    // Called just after a rising edge; start is held for exactly one cycle.
    task automatic apply_stimulus(input bit is_b, input logic [10:0] len);
        if (is_b) begin bus_b.start = 1'b1; bus_b.frame_len = len; end
        else      begin bus_a.start = 1'b1; bus_a.frame_len = len; end
        start_cyc = cyc;
        @(posedge clk); #1;
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
    endtask

    task automatic wait_done(input bit is_b, input int budget);
        int n = 0;
        while ((is_b ? done_cnt_b : done_cnt_a) == 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        check_output("done_seen", 32'((is_b ? done_cnt_b : done_cnt_a) != 0), 32'd1);
    endtask

    task automatic check_stream(input string tag, input bit is_b, input logic [31:0] w0,
                                input logic [31:0] w1, input int len, input bit lsb);
        logic [31:0] word;
        logic [7:0]  exp_byte;
        logic [8:0]  obs;
        int          lane;
        int          got;
        got = is_b ? byte_q_b.size() : byte_q_a.size();
        check_output({tag, "_count"}, 32'(got), 32'(len));
        for (int i = 0; i < len; i++) begin
            word     = (i < 4) ? w0 : w1;
            lane     = lsb ? (i % 4) : (3 - (i % 4));
            exp_byte = word[lane*8 +: 8];
            if (i < got) obs = is_b ? {last_q_b[i], byte_q_b[i]} : {last_q_a[i], byte_q_a[i]};
            else         obs = 9'h1ff;
            check_output($sformatf("%s_byte%0d", tag, i), 32'(obs), 32'({(i == len - 1), exp_byte}));
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit         prev_hold;
        logic [7:0] prev_data;

        rst_n = 1'b0;
        bus_a.start = 1'b0; bus_a.frame_len = '0; bus_a.tx_ready = 1'b1;
        bus_b.start = 1'b0; bus_b.frame_len = '0; bus_b.tx_ready = 1'b1;
        @(negedge clk);
        check_output("reset_ctrl", 32'({bus_a.tx_valid, bus_a.tx_last, bus_a.busy, bus_a.done, bus_a.fifo_rd_en}), 32'd0);
        check_output("reset_data", 32'(bus_a.tx_data), 32'd0);

        $display("[TB] len=8 gapless frame");
        do_reset();
        push_a(32'h44332211); push_a(32'h88776655);
        apply_stimulus(1'b0, 11'd8);
        wait_done(1'b0, 60);
        check_stream("len8", 1'b0, 32'h44332211, 32'h88776655, 8, 1'b1);
        check_output("len8_latency", 32'(cyc_q_a[0] - start_cyc), 32'd3);
        check_output("len8_gapless", 32'(cyc_q_a[7] - cyc_q_a[0]), 32'd7);
        check_output("len8_reads", 32'(rd_cnt_a), 32'd2);
        check_output("len8_done_cnt", 32'(done_cnt_a), 32'd1);
        check_output("len8_done_cyc", 32'(done_cyc_a - cyc_q_a[7]), 32'd1);
        check_output("len8_done_busy", 32'(done_busy_a), 32'd0);

        $display("[TB] len=5 frame discards tail bytes");
        do_reset();
        push_a(32'h44332211); push_a(32'h88776655);
        apply_stimulus(1'b0, 11'd5);
        wait_done(1'b0, 60);
        repeat (4) @(posedge clk); #1;
        check_stream("len5", 1'b0, 32'h44332211, 32'h88776655, 5, 1'b1);
        check_output("len5_reads", 32'(rd_cnt_a), 32'd2);
        check_output("len5_busy", 32'(bus_a.busy), 32'd0);

        $display("[TB] len=8 with tx_ready toggling");
        do_reset();
        push_a(32'h44332211); push_a(32'h88776655);
        apply_stimulus(1'b0, 11'd8);
        prev_hold = 1'b0;
        prev_data = '0;
        for (int k = 0; k < 120 && done_cnt_a == 0; k++) begin
            bus_a.tx_ready = (k % 3 == 0);
            @(negedge clk);
            if (prev_hold) begin
                check_output("hold_valid", 32'(bus_a.tx_valid), 32'd1);
                check_output("hold_data", 32'(bus_a.tx_data), 32'(prev_data));
            end
            prev_hold = bus_a.tx_valid && !bus_a.tx_ready;
            prev_data = bus_a.tx_data;
            @(posedge clk); #1;
        end
        bus_a.tx_ready = 1'b1;
        check_output("toggle_done", 32'(done_cnt_a), 32'd1);
        check_stream("toggle", 1'b0, 32'h44332211, 32'h88776655, 8, 1'b1);
        check_output("toggle_reads", 32'(rd_cnt_a), 32'd2);
        check_output("toggle_overread", 32'(over_a), 32'd0);

        $display("[TB] FIFO underrun then refill");
        do_reset();
        push_a(32'h44332211);
        apply_stimulus(1'b0, 11'd8);
        repeat (10) @(posedge clk); #1;
        check_output("underrun_bytes", 32'(byte_q_a.size()), 32'd4);
        check_output("underrun_valid", 32'(bus_a.tx_valid), 32'd0);
        check_output("underrun_reads", 32'(rd_cnt_a), 32'd1);
        push_a(32'h88776655);
        wait_done(1'b0, 60);
        check_stream("refill", 1'b0, 32'h44332211, 32'h88776655, 8, 1'b1);
        check_output("refill_reads", 32'(rd_cnt_a), 32'd2);
        check_output("refill_overread", 32'(over_a), 32'd0);

        $display("[TB] zero-length start ignored");
        do_reset();
        push_a(32'h44332211); push_a(32'h88776655);
        apply_stimulus(1'b0, 11'd0);
        repeat (10) @(posedge clk); #1;
        check_output("len0_reads", 32'(rd_cnt_a), 32'd0);
        check_output("len0_bytes", 32'(byte_q_a.size()), 32'd0);
        check_output("len0_done", 32'(done_cnt_a), 32'd0);
        check_output("len0_busy", 32'(bus_a.busy), 32'd0);

        $display("[TB] start while busy ignored");
        do_reset();
        push_a(32'h44332211); push_a(32'h88776655);
        apply_stimulus(1'b0, 11'd8);
        apply_stimulus(1'b0, 11'd4);
        wait_done(1'b0, 60);
        check_stream("busy_start", 1'b0, 32'h44332211, 32'h88776655, 8, 1'b1);
        check_output("busy_start_reads", 32'(rd_cnt_a), 32'd2);
        check_output("busy_start_done", 32'(done_cnt_a), 32'd1);

        $display("[TB] reset mid-frame");
        do_reset();
        push_a(32'h44332211); push_a(32'h88776655);
        apply_stimulus(1'b0, 11'd8);
        for (int n = 0; byte_q_a.size() < 3 && n < 50; n++) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_output("abort_ctrl", 32'({bus_a.tx_valid, bus_a.tx_last, bus_a.busy, bus_a.done, bus_a.fifo_rd_en}), 32'd0);
        check_output("abort_data", 32'(bus_a.tx_data), 32'd0);
        do_reset();
        push_a(32'hDDCCBBAA);
        apply_stimulus(1'b0, 11'd4);
        wait_done(1'b0, 60);
        check_stream("after_abort", 1'b0, 32'hDDCCBBAA, 32'h0, 4, 1'b1);
        check_output("after_abort_reads", 32'(rd_cnt_a), 32'd1);

        $display("[TB] MSB-first, read latency 2");
        do_reset();
        push_b(32'h44332211); push_b(32'h88776655);
        apply_stimulus(1'b1, 11'd8);
        wait_done(1'b1, 60);
        check_stream("msb", 1'b1, 32'h44332211, 32'h88776655, 8, 1'b0);
        check_output("msb_latency", 32'(cyc_q_b[0] - start_cyc), 32'd4);
        check_output("msb_gapless", 32'(cyc_q_b[7] - cyc_q_b[0]), 32'd7);
        check_output("msb_reads", 32'(rd_cnt_b), 32'd2);
        check_output("msb_overread", 32'(over_b), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
